// File: rtl/pll_lock_sequencer.sv
// PLL reset/lock sequencer on the free-running reference clock: pulses the PLL
// reset, waits for lock with timeout and retry, and releases the core reset once lock is stable.
module pll_lock_sequencer #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 74250,
  parameter int STABLE_CYCLES = 1024,
  parameter int RETRY_W       = 4
) (
  input  logic               refclk,
  input  logic               rst_n,
  input  logic               locked,
  input  logic               reinit,
  output logic               pll_rst,
  output logic               core_reset,
  output logic               ready,
  output logic               lock_lost,
  output logic [RETRY_W-1:0] retry_count
);

  localparam int CNT_MAX_A = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
  localparam int CNT_MAX   = (CNT_MAX_A > STABLE_CYCLES) ? CNT_MAX_A : STABLE_CYCLES;
  localparam int CNT_W     = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0]   RST_LAST     = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX    = '1;

  localparam logic [1:0] ST_PLL_RESET = 2'd0;
  localparam logic [1:0] ST_WAIT_LOCK = 2'd1;
  localparam logic [1:0] ST_STABLE    = 2'd2;
  localparam logic [1:0] ST_RUN       = 2'd3;

  logic [1:0]       state;
  logic [1:0]       next_state;
  logic [CNT_W-1:0] count;
  logic             cnt_clear;
  logic             retry_inc;
  logic             lost_set;
  logic             locked_meta;
  logic             locked_s;

  // locked comes straight from the PLL analog side; every decision below uses locked_s only.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      locked_meta <= 1'b0;
      locked_s    <= 1'b0;
    end else begin
      locked_meta <= locked;
      locked_s    <= locked_meta;
    end
  end

  always_comb begin
    next_state = state;
    cnt_clear  = 1'b0;
    retry_inc  = 1'b0;
    lost_set   = 1'b0;
    case (state)
      ST_PLL_RESET: begin
        if (reinit) begin
          cnt_clear = 1'b1;
        end else if (count == RST_LAST) begin
          next_state = ST_WAIT_LOCK;
        end
      end
      ST_WAIT_LOCK: begin
        if (reinit) begin
          next_state = ST_PLL_RESET;
        end else if (locked_s) begin
          next_state = ST_STABLE;
        end else if (count == TIMEOUT_LAST) begin
          next_state = ST_PLL_RESET;
          retry_inc  = 1'b1;
        end
      end
      ST_STABLE: begin
        if (reinit) begin
          next_state = ST_PLL_RESET;
        end else if (!locked_s) begin
          next_state = ST_WAIT_LOCK;
        end else if (count == STABLE_LAST) begin
          next_state = ST_RUN;
        end
      end
      ST_RUN: begin
        // A software restart wins over a coincident lock drop, so it is not reported as lost.
        if (reinit) begin
          next_state = ST_PLL_RESET;
        end else if (!locked_s) begin
          next_state = ST_PLL_RESET;
          lost_set   = 1'b1;
        end
      end
      default: begin
        next_state = ST_PLL_RESET;
      end
    endcase
    if (next_state != state) begin
      cnt_clear = 1'b1;
    end
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_PLL_RESET;
      count <= '0;
    end else begin
      state <= next_state;
      if (cnt_clear) begin
        count <= '0;
      end else if (state != ST_RUN) begin
        count <= count + 1'b1;
      end
    end
  end

  // Outputs are decoded from next_state so the registered values track the state register exactly.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      pll_rst     <= 1'b1;
      core_reset  <= 1'b1;
      ready       <= 1'b0;
      lock_lost   <= 1'b0;
      retry_count <= '0;
    end else begin
      pll_rst    <= (next_state == ST_PLL_RESET);
      core_reset <= (next_state != ST_RUN);
      ready      <= (next_state == ST_RUN);
      if (lost_set) begin
        lock_lost <= 1'b1;
      end
      if (retry_inc && (retry_count != RETRY_MAX)) begin
        retry_count <= retry_count + 1'b1;
      end
    end
  end

endmodule
